// File: rtl/vco_freq_counter_pkg.sv
// Shared definitions for the VCO frequency counter: FSM state encoding and
// default sizing constants.
package vco_fcnt_pkg;

  localparam int CNT_W_DEFAULT       = 16;
  localparam int WIN_W_DEFAULT       = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    FINISH  = 2'd2
  } fcnt_state_t;

endpackage

// File: rtl/vco_freq_counter_if.sv
// Control/result bundle between the calibration logic (master) and the
// VCO frequency counter (slave).
interface vco_freq_counter_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);

  logic             START;
  logic [WIN_W-1:0] WINDOW_CYCLES;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] COUNT;
  logic             OVERFLOW;

  modport master (
    output START, WINDOW_CYCLES,
    input  BUSY, DONE, COUNT, OVERFLOW
  );

  modport slave (
    input  START, WINDOW_CYCLES,
    output BUSY, DONE, COUNT, OVERFLOW
  );

endinterface

// File: rtl/vco_freq_counter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous VCO tap followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module vco_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/vco_freq_counter.sv
// Counts rising edges of a divided VCO over a programmable window of CLK cycles.
// Define VCO_FCNT_CONT_EN for back-to-back continuous windows without START.
module vco_freq_counter
  import vco_fcnt_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int WIN_W       = WIN_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESETB,
  input  logic               VCO_DIV_IN,
  vco_freq_counter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  fcnt_state_t      state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             edge_pulse;
  logic             start_ok;
  logic [WIN_W-1:0] win_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_inc;

  vco_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (CLK),
    .resetb     (RESETB),
    .async_in   (VCO_DIV_IN),
    .rise_pulse (edge_pulse)
  );

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Results are loaded on the edge that enters FINISH so COUNT is valid
  // during the DONE cycle itself.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

`ifdef VCO_FCNT_CONT_EN
    start_ok = 1'b1;
    win_eff  = (bus.WINDOW_CYCLES == '0) ? WIN_ONE : bus.WINDOW_CYCLES;
`else
    start_ok = bus.START;
    win_eff  = bus.WINDOW_CYCLES;
`endif

    cnt_inc = cnt_q;
    sat_inc = sat_q;
    if (edge_pulse) begin
      if (cnt_q == CNT_MAX) sat_inc = 1'b1;
      else                  cnt_inc = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          timer_d = win_eff;
          cnt_d   = '0;
          sat_d   = 1'b0;
          if (win_eff == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            count_d = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = MEASURE;
          end
        end
      end
      MEASURE: begin
        cnt_d   = cnt_inc;
        sat_d   = sat_inc;
        timer_d = timer_q - WIN_ONE;
        if (timer_q == WIN_ONE) begin
          state_d = FINISH;
          done_d  = 1'b1;
          count_d = cnt_inc;
          ovf_d   = sat_inc;
        end
      end
      FINISH: begin
`ifdef VCO_FCNT_CONT_EN
        // The FINISH cycle is the first cycle of the next window, so no edge is lost.
        cnt_d   = CNT_W'(edge_pulse);
        sat_d   = 1'b0;
        timer_d = win_eff - WIN_ONE;
        if (win_eff == WIN_ONE) begin
          state_d = FINISH;
          done_d  = 1'b1;
          count_d = CNT_W'(edge_pulse);
          ovf_d   = 1'b0;
        end else begin
          state_d = MEASURE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.BUSY     = (state_q == MEASURE);
  assign bus.DONE     = done_q;
  assign bus.COUNT    = count_q;
  assign bus.OVERFLOW = ovf_q;

endmodule

// File: tb/tb_vco_freq_counter.sv
// Directed bench for vco_freq_counter: a 16-bit and an 8-bit counter driven in
// parallel from the same VCO source and control bundle.
module tb_vco_freq_counter;
  import vco_fcnt_pkg::*;

  logic clk = 1'b0;
  logic resetb;
  logic vco = 1'b0;
  logic vcoHold = 1'b0;
  int   vcoHalf = 20;
  int   checks = 0;
  int   errors = 0;
  int   doneAt, busyFirst, busyAny, extraDone, busyLater;

  vco_freq_counter_if #(.CNT_W(16), .WIN_W(16)) bus16 ();
  vco_freq_counter_if #(.CNT_W(8),  .WIN_W(16)) bus8 ();

  vco_freq_counter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) dut16 (
    .CLK(clk), .RESETB(resetb), .VCO_DIV_IN(vco), .bus(bus16)
  );

  vco_freq_counter #(.CNT_W(8), .WIN_W(16), .SYNC_STAGES(2)) dut8 (
    .CLK(clk), .RESETB(resetb), .VCO_DIV_IN(vco), .bus(bus8)
  );

  always #5 clk = ~clk;

  // VCO toggles only on multiples of 10 time units, i.e. never on a rising CLK edge.
  initial begin
    forever begin
      if (vcoHalf == 0) begin
        #10;
        vco = vcoHold;
      end else begin
        #(vcoHalf);
        vco = ~vco;
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected,
                             input int tol = 0);
    int diff;
    checks++;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
    end
  endtask

  task automatic driveStart(input logic v);
    bus16.START = v;
    bus8.START  = v;
  endtask

  task automatic driveWindow(input int w);
    bus16.WINDOW_CYCLES = 16'(w);
    bus8.WINDOW_CYCLES  = 16'(w);
  endtask

  // Pulses START for one edge; returns at the negedge right after that edge.
  task automatic applyStimulus(input int w);
    @(negedge clk);
    driveWindow(w);
    driveStart(1'b1);
    @(negedge clk);
    driveStart(1'b0);
  endtask

  // Sample at negedges, k=1 being the first after the START edge.
  task automatic waitDone(input int limit, input bit poke, output int at,
                          output int bFirst, output int bAny);
    at     = -1;
    bAny   = 0;
    bFirst = int'(bus16.BUSY);
    for (int k = 1; k <= limit; k++) begin
      if (bus16.BUSY) bAny = 1;
      if (bus16.DONE) begin
        at = k;
        break;
      end
      @(negedge clk);
      driveStart(poke && bus16.BUSY);
    end
    driveStart(1'b0);
  endtask

  task automatic countDone(input int cycles, output int dones, output int busys);
    dones = 0;
    busys = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus16.DONE) dones++;
      if (bus16.BUSY) busys++;
    end
  endtask

  initial begin
    resetb = 1'b0;
    driveStart(1'b0);
    driveWindow(0);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",  int'(bus16.BUSY), 0);
    checkOutput("reset_done",  int'(bus16.DONE), 0);
    checkOutput("reset_count", int'(bus16.COUNT), 0);
    checkOutput("reset_ovf",   int'(bus16.OVERFLOW), 0);
    resetb = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] 25 MHz input, W=1000");
    applyStimulus(1000);
    waitDone(1100, 1'b0, doneAt, busyFirst, busyAny);
    checkOutput("w1000_done_at", doneAt, 1001);
    checkOutput("w1000_busy_first", busyFirst, 1);
    checkOutput("w1000_busy_in_finish", int'(bus16.BUSY), 0);
    checkOutput("w1000_count16", int'(bus16.COUNT), 250, 1);
    checkOutput("w1000_ovf16", int'(bus16.OVERFLOW), 0);
    checkOutput("w1000_count8", int'(bus8.COUNT), 250, 1);
    @(negedge clk);
    checkOutput("w1000_done_one_cycle", int'(bus16.DONE), 0);
    checkOutput("w1000_count_holds", int'(bus16.COUNT), 250, 1);

    $display("[TB] 25 MHz input, W=2000 (8-bit saturation)");
    applyStimulus(2000);
    waitDone(2100, 1'b0, doneAt, busyFirst, busyAny);
    checkOutput("w2000_done_at", doneAt, 2001);
    checkOutput("w2000_count8", int'(bus8.COUNT), 255);
    checkOutput("w2000_ovf8", int'(bus8.OVERFLOW), 1);
    checkOutput("w2000_count16", int'(bus16.COUNT), 500, 1);
    checkOutput("w2000_ovf16", int'(bus16.OVERFLOW), 0);

    $display("[TB] 25 MHz input, W=400");
    applyStimulus(400);
    waitDone(500, 1'b0, doneAt, busyFirst, busyAny);
    checkOutput("w400_done_at", doneAt, 401);
    checkOutput("w400_count8", int'(bus8.COUNT), 100, 1);
    checkOutput("w400_ovf8", int'(bus8.OVERFLOW), 0);

    $display("[TB] W=0");
    applyStimulus(0);
    waitDone(20, 1'b0, doneAt, busyFirst, busyAny);
    checkOutput("w0_done_at", doneAt, 1);
    checkOutput("w0_count", int'(bus16.COUNT), 0);
    checkOutput("w0_ovf", int'(bus16.OVERFLOW), 0);
    checkOutput("w0_busy_any", busyAny, 0);

    $display("[TB] W=100 with extra START pulses");
    applyStimulus(100);
    waitDone(200, 1'b1, doneAt, busyFirst, busyAny);
    checkOutput("w100_done_at", doneAt, 101);
    checkOutput("w100_count", int'(bus16.COUNT), 25, 1);
    countDone(50, extraDone, busyLater);
    checkOutput("w100_extra_done", extraDone, 0);
    checkOutput("w100_no_restart", busyLater, 0);

    $display("[TB] reset during W=500");
    applyStimulus(500);
    repeat (49) @(negedge clk);
    checkOutput("w500_busy_before_reset", int'(bus16.BUSY), 1);
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_busy",  int'(bus16.BUSY), 0);
    checkOutput("midrst_done",  int'(bus16.DONE), 0);
    checkOutput("midrst_count", int'(bus16.COUNT), 0);
    checkOutput("midrst_ovf",   int'(bus16.OVERFLOW), 0);
    checkOutput("midrst_state", int'(dut16.state_q), int'(IDLE));
    resetb = 1'b1;
    countDone(600, extraDone, busyLater);
    checkOutput("postrst_no_done", extraDone, 0);
    checkOutput("postrst_no_busy", busyLater, 0);

    $display("[TB] constant-high then constant-low input");
    vcoHold = 1'b1;
    vcoHalf = 0;
    repeat (20) @(negedge clk);
    applyStimulus(100);
    waitDone(200, 1'b0, doneAt, busyFirst, busyAny);
    checkOutput("hold_hi_done_at", doneAt, 101);
    checkOutput("hold_hi_count", int'(bus16.COUNT), 0);
    vcoHold = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(100);
    waitDone(200, 1'b0, doneAt, busyFirst, busyAny);
    checkOutput("hold_lo_done_at", doneAt, 101);
    checkOutput("hold_lo_count", int'(bus16.COUNT), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vco_freq_counter.md
# vco_freq_counter

Measures the frequency of a divided VCO output by counting its rising edges over a programmable window of system-clock cycles. Sits directly downstream of the VCO frequency divider: one divider tap (typically the divide-by-8 output) drives `VCO_DIV_IN`, and the result is read by the digital control/calibration logic. The divider output is asynchronous to `CLK`, so it is synchronized and edge-detected before counting.

## Interface
- `CNT_W`, 16: width of the edge counter and `COUNT`.
- `WIN_W`, 16: width of `WINDOW_CYCLES` and the window timer.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizer; minimum 2.
- `CLK`  in  1  system clock; all logic is on its rising edge.
- `RESETB`  in  1  asynchronous active-low reset.
- `VCO_DIV_IN`  in  1  divided VCO signal, asynchronous to `CLK`.
- `START`  in  1  one-cycle request to begin a measurement; honoured only in IDLE.
- `WINDOW_CYCLES`  in  WIN_W  measurement window length in `CLK` cycles; sampled when `START` is accepted.
- `BUSY`  out  1  high in MEASURE.
- `DONE`  out  1  one-cycle pulse when `COUNT` is updated.
- `COUNT`  out  CNT_W  rising-edge count of the last completed window; holds until the next completion.
- `OVERFLOW`  out  1  the last completed window saturated the counter.

## Operation
- Reset values: `BUSY`=0, `DONE`=0, `COUNT`=0, `OVERFLOW`=0. Synchronizer and edge-detect registers reset to 0. FSM resets to IDLE.
- Synchronizer: `SYNC_STAGES` flops, then one history flop. Rising edge = synced high AND history low. This path runs continuously in every state, so starting a window never creates a false edge.
- FSM states:
  - IDLE: on `START`=1, latch `WINDOW_CYCLES` into the timer and clear the edge counter and the saturation flag. If the latched value is 0, go to FINISH; otherwise go to MEASURE.
  - MEASURE: each cycle, if an edge is detected, increment the counter. Decrement the timer. When the timer reaches 1 in this cycle, go to FINISH after counting this cycle's edge.
  - FINISH: copy the counter to `COUNT` and the saturation flag to `OVERFLOW`, pulse `DONE`, then go to IDLE.
- Arithmetic: the counter saturates at 2^CNT_W−1. An increment attempted at that value sets the saturation flag; the counter does not wrap.
- `START` is ignored in MEASURE and FINISH. No queuing.
- Accuracy: exact only if `VCO_DIV_IN` high and low phases each last at least 2 `CLK` periods. Faster inputs alias. The upstream tap must be chosen to meet this.
- Reset asserted mid-measurement returns to IDLE immediately and clears all outputs. The partial count is discarded.

## Timing
- `START` sampled high at edge t: `BUSY`=1 from t+1 through t+W, where W=`WINDOW_CYCLES`. FINISH occurs at t+W+1, when `DONE`=1 and `COUNT` is valid, and `BUSY`=0.
- W=0: `DONE` at t+1 with `COUNT`=0, `OVERFLOW`=0. `BUSY` never asserts.
- An input edge reaches the counter SYNC_STAGES+1 cycles after it is sampled. The window therefore counts edges from that shifted interval. The fixed offset is accepted and not compensated.
- Earliest next accepted `START`: cycle t+W+2.

## Configuration
- `VCO_FCNT_CONT_EN` defined: continuous mode.
  - FINISH goes directly to a new MEASURE using a freshly sampled `WINDOW_CYCLES`, without requiring `START`. There are no gaps between windows.
  - `DONE` pulses once per window.
  - `START` is ignored. Measurement begins automatically on the first cycle after reset deassertion.
  - A sampled `WINDOW_CYCLES`=0 is treated as 1.
- Not defined: single-shot behaviour as described above.

## Structure
- Package `vco_fcnt_pkg`: FSM state encoding (IDLE, MEASURE, FINISH) and the default `CNT_W`, `WIN_W` and `SYNC_STAGES` constants.
- Sub-module `vco_sync_edge_det`: parameterized synchronizer chain plus rising-edge pulse. It is reusable for other asynchronous VCO taps.
- Top level: FSM, window timer, saturating counter, output registers.

## Test plan
- `CLK` 100 MHz, `VCO_DIV_IN` 25 MHz square wave, W=1000, `START` pulse → `DONE` exactly 1001 cycles after `START`; `COUNT`=250±1; `OVERFLOW`=0.
- `CNT_W`=8, input period 4 cycles, W=2000 → `COUNT`=255, `OVERFLOW`=1. A subsequent run with W=400 → `COUNT`=100±1, `OVERFLOW`=0.
- W=0 → `DONE` on the next cycle, `COUNT`=0, `BUSY` stays 0. Extra `START` pulses during MEASURE of W=100 → exactly one `DONE`.
- `RESETB` low for 3 cycles at cycle 50 of W=500 → all outputs 0 and FSM in IDLE. No `DONE` without a new `START`.
- Input held constant high during a window, then constant low during another → `COUNT`=0 both times. No spurious edge at window start.
- With `VCO_FCNT_CONT_EN` defined, W=200, 10 MHz input → `DONE` every 200 cycles; each `COUNT`=20±1. `START` has no effect.
